// File: rtl/noc_credit_link_tx.sv
`default_nettype none
// ============================================================================
// Module  : noc_credit_link_tx
// Brief   : Credit-based flit transmitter with per-packet destination lock.
// Revision: 1.0
// ============================================================================
module noc_credit_link_tx #(
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FLIT_WIDTH-1:0]   in_data,
  input  logic [DEST_WIDTH-1:0]   in_dest,
  input  logic                    in_is_tail,
  output logic [FLIT_WIDTH-1:0]   data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    pkt_active,
  output logic                    err_credit_overflow
);

  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_IN_PKT = 1'b1;
  localparam logic [CREDIT_WIDTH-1:0] c_MAX_CREDIT = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] c_ONE        = CREDIT_WIDTH'(1);

  logic [0:0]            r_state;
  logic [DEST_WIDTH-1:0] r_dest_lock;
  logic [CREDIT_WIDTH-1:0] r_credit;
  logic                  w_fire;
  logic                  w_ovf;

  assign in_ready     = (r_credit != '0) && !rst_noc;
  assign w_fire       = in_valid && in_ready;
  assign w_ovf        = credit_in && !w_fire && (r_credit == c_MAX_CREDIT);
  assign credit_count = r_credit;
  assign pkt_active   = (r_state == c_IN_PKT);

  // A returned credit that would exceed the buffer depth is dropped and flagged.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      r_credit            <= c_MAX_CREDIT;
      err_credit_overflow <= 1'b0;
    end else begin
      if (w_fire && !credit_in)
        r_credit <= r_credit - c_ONE;
      else if (credit_in && !w_fire && !w_ovf)
        r_credit <= r_credit + c_ONE;
      if (w_ovf)
        err_credit_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      r_state     <= c_IDLE;
      r_dest_lock <= '0;
    end else if (w_fire) begin
      case (r_state)
        c_IDLE: begin
          if (!in_is_tail) begin
            r_state     <= c_IN_PKT;
            r_dest_lock <= in_dest;
          end
        end
        default: begin
          if (in_is_tail)
            r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Body and tail flits reuse the head's destination.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= w_fire;
      if (w_fire) begin
        data_out    <= in_data;
        dest_out    <= (r_state == c_IN_PKT) ? r_dest_lock : in_dest;
        is_tail_out <= in_is_tail;
      end
    end
  end

endmodule
`default_nettype wire
